// File: rtl/dyn_branch_predictor.sv
// Fetch-stage jump/branch unit with a direct-mapped, tagged table of saturating
// counters trained from execute; the static backward-taken rule covers table misses.
module dyn_branch_predictor #(
  parameter int ADDR_W          = 32,
  parameter int IDX_BITS        = 4,
  parameter int TAG_BITS        = 8,
  parameter int CTR_BITS        = 2,
  parameter int STATIC_FALLBACK = 1,
  parameter int STAT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] instruction,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] PC1,
  input  logic              JRSignal,
  input  logic              BranchSignal,
  input  logic              Hit,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  output logic              prediction,
  output logic [ADDR_W-1:0] JumpToAddress,
  output logic              S0,
  output logic              S1,
  output logic              IF_flush,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  localparam logic [5:0] OP_J   = 6'h2;
  localparam logic [5:0] OP_JAL = 6'h3;
  localparam logic [5:0] OP_BEQ = 6'h4;
  localparam logic [5:0] OP_BNE = 6'h5;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic [5:0]          opcode;
  logic                is_jump;
  logic                is_branch;
  logic [ADDR_W-1:0]   jump_target;
  logic [ADDR_W-1:0]   branch_target;
  logic                backward;

  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic                lookup_hit;
  logic [IDX_BITS-1:0] uidx;
  logic [TAG_BITS-1:0] utag;
  logic                upd_hit;

  assign opcode        = instruction[ADDR_W-1 -: 6];
  assign is_jump       = (opcode == OP_J) || (opcode == OP_JAL);
  assign is_branch     = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign jump_target   = {{(ADDR_W-26){1'b0}}, instruction[25:0]};
  assign branch_target = PC1 + {{(ADDR_W-16){instruction[15]}}, instruction[15:0]};
  assign backward      = branch_target < PC1;

  assign idx        = PC[IDX_BITS-1:0];
  assign tag        = PC[IDX_BITS+TAG_BITS-1:IDX_BITS];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign uidx       = upd_pc[IDX_BITS-1:0];
  assign utag       = upd_pc[IDX_BITS+TAG_BITS-1:IDX_BITS];
  assign upd_hit    = valid_q[uidx] && (tag_q[uidx] == utag);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC[ADDR_W-1:IDX_BITS+TAG_BITS], upd_pc[ADDR_W-1:IDX_BITS+TAG_BITS]};

  always_comb begin
    prediction    = 1'b0;
    JumpToAddress = '0;
    if (is_jump) begin
      JumpToAddress = jump_target;
    end else if (is_branch) begin
      // Table state is read pre-update; training becomes visible a cycle later.
      prediction    = lookup_hit ? ctr_q[idx][CTR_BITS-1] : ((STATIC_FALLBACK != 0) && backward);
      JumpToAddress = prediction ? branch_target : PC1;
    end
  end

  assign S1       = JRSignal | (~Hit & BranchSignal);
  assign S0       = (~JRSignal & (is_jump | is_branch)) | (~Hit & BranchSignal);
  assign IF_flush = JRSignal | (~Hit & BranchSignal);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (BranchSignal) begin
      if (upd_hit) begin
        if (upd_taken && (ctr_q[uidx] != CTR_MAX))
          ctr_q[uidx] <= ctr_q[uidx] + CTR_BITS'(1);
        else if (!upd_taken && (ctr_q[uidx] != '0))
          ctr_q[uidx] <= ctr_q[uidx] - CTR_BITS'(1);
      end else begin
        valid_q[uidx] <= 1'b1;
        tag_q[uidx]   <= utag;
        ctr_q[uidx]   <= upd_taken ? CTR_WT : CTR_WNT;
      end
      if (branch_count != '1)
        branch_count <= branch_count + STAT_W'(1);
      if (!Hit && (mispredict_count != '1))
        mispredict_count <= mispredict_count + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Directed bench for dyn_branch_predictor: static fallback, counter training and
// saturation, aliasing, jump decode, flush selects, statistics and reset priority.
module tb_dyn_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic [31:0] PC1;
  logic        JRSignal;
  logic        BranchSignal;
  logic        Hit;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        prediction;
  logic [31:0] JumpToAddress;
  logic        S0;
  logic        S1;
  logic        IF_flush;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  logic        prediction4;
  logic [31:0] jta4;
  logic        s0_4;
  logic        s1_4;
  logic        flush4;
  logic [3:0]  branch_count4;
  logic [3:0]  mispredict_count4;

  int tests_run;
  int tests_failed;

  localparam logic [31:0] BEQ_BACK = 32'h1000_FFFC;
  localparam logic [31:0] BEQ_FWD  = 32'h1000_0004;
  localparam logic [31:0] BNE_BACK = 32'h1400_FFFC;
  localparam logic [31:0] J_ABC    = 32'h0800_0ABC;

  dyn_branch_predictor dut (
    .clk(clk), .rst(rst), .instruction(instruction), .PC(PC), .PC1(PC1),
    .JRSignal(JRSignal), .BranchSignal(BranchSignal), .Hit(Hit),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .prediction(prediction),
    .JumpToAddress(JumpToAddress), .S0(S0), .S1(S1), .IF_flush(IF_flush),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  dyn_branch_predictor #(.STAT_W(4)) dut4 (
    .clk(clk), .rst(rst), .instruction(instruction), .PC(PC), .PC1(PC1),
    .JRSignal(JRSignal), .BranchSignal(BranchSignal), .Hit(Hit),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .prediction(prediction4),
    .JumpToAddress(jta4), .S0(s0_4), .S1(s1_4), .IF_flush(flush4),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    PC = pc;
    PC1 = pc + 32'd1;
    instruction = instr;
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic hit);
    BranchSignal = 1'b1;
    upd_pc = pc;
    upd_taken = taken;
    Hit = hit;
    @(posedge clk); #1;
    BranchSignal = 1'b0;
    Hit = 1'b1;
  endtask

  task automatic test_reset();
    fetch(32'h0, 32'h0);
    tests_run++;
    if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", branch_count, mispredict_count);
    end
    tests_run++;
    if ({prediction, JumpToAddress, S0, S1, IF_flush} !== {1'b0, 32'h0, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_idle: got pred=%b jta=%h s0=%b s1=%b fl=%b expected 0 0 0 0 0",
               prediction, JumpToAddress, S0, S1, IF_flush);
    end
  endtask

  task automatic test_static_fallback();
    fetch(32'h20, BEQ_BACK);
    tests_run++;
    if (prediction !== 1'b1 || JumpToAddress !== 32'h1D) begin
      tests_failed++;
      $display("FAIL static_back: got pred=%b jta=%h expected 1 0000001d", prediction, JumpToAddress);
    end
    fetch(32'h20, BEQ_FWD);
    tests_run++;
    if (prediction !== 1'b0 || JumpToAddress !== 32'h21) begin
      tests_failed++;
      $display("FAIL static_fwd: got pred=%b jta=%h expected 0 00000021", prediction, JumpToAddress);
    end
    fetch(32'h20, BNE_BACK);
    tests_run++;
    if (prediction !== 1'b1 || S0 !== 1'b1 || S1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL static_bne: got pred=%b s0=%b s1=%b expected 1 1 0", prediction, S0, S1);
    end
  endtask

  task automatic test_training();
    train(32'h20, 1'b1, 1'b0);
    fetch(32'h20, BEQ_FWD);
    tests_run++;
    if (prediction !== 1'b1 || JumpToAddress !== 32'h25) begin
      tests_failed++;
      $display("FAIL train_alloc: got pred=%b jta=%h expected 1 00000025", prediction, JumpToAddress);
    end
    train(32'h20, 1'b1, 1'b1);
    train(32'h20, 1'b0, 1'b0);
    fetch(32'h20, BEQ_FWD);
    tests_run++;
    if (prediction !== 1'b1) begin
      tests_failed++;
      $display("FAIL train_sat_hi: got pred=%b expected 1", prediction);
    end
    train(32'h20, 1'b0, 1'b0);
    fetch(32'h20, BEQ_FWD);
    tests_run++;
    if (prediction !== 1'b0 || JumpToAddress !== 32'h21) begin
      tests_failed++;
      $display("FAIL train_dec: got pred=%b jta=%h expected 0 00000021", prediction, JumpToAddress);
    end
    train(32'h20, 1'b0, 1'b1);
    train(32'h20, 1'b0, 1'b1);
    train(32'h20, 1'b1, 1'b0);
    fetch(32'h20, BEQ_BACK);
    tests_run++;
    if (prediction !== 1'b0 || JumpToAddress !== 32'h21) begin
      tests_failed++;
      $display("FAIL train_sat_lo: got pred=%b jta=%h expected 0 00000021", prediction, JumpToAddress);
    end
  endtask

  task automatic test_aliasing();
    train(32'h20, 1'b1, 1'b0);
    train(32'h20, 1'b1, 1'b1);
    fetch(32'h20, BEQ_FWD);
    tests_run++;
    if (prediction !== 1'b1) begin
      tests_failed++;
      $display("FAIL alias_pre: got pred=%b expected 1", prediction);
    end
    train(32'h120, 1'b0, 1'b0);
    fetch(32'h20, BEQ_FWD);
    tests_run++;
    if (prediction !== 1'b0 || JumpToAddress !== 32'h21) begin
      tests_failed++;
      $display("FAIL alias_miss_fwd: got pred=%b jta=%h expected 0 00000021", prediction, JumpToAddress);
    end
    fetch(32'h20, BEQ_BACK);
    tests_run++;
    if (prediction !== 1'b1 || JumpToAddress !== 32'h1D) begin
      tests_failed++;
      $display("FAIL alias_miss_back: got pred=%b jta=%h expected 1 0000001d", prediction, JumpToAddress);
    end
    fetch(32'h120, BEQ_BACK);
    tests_run++;
    if (prediction !== 1'b0 || JumpToAddress !== 32'h121) begin
      tests_failed++;
      $display("FAIL alias_retag: got pred=%b jta=%h expected 0 00000121", prediction, JumpToAddress);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    BranchSignal = 1'b1;
    upd_pc = 32'h30;
    upd_taken = 1'b1;
    Hit = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    BranchSignal = 1'b0;
    Hit = 1'b1;
    tests_run++;
    if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL rstpri_stats: got %0d/%0d expected 0/0", branch_count, mispredict_count);
    end
    fetch(32'h30, BEQ_FWD);
    tests_run++;
    if (prediction !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstpri_dropped: got pred=%b expected 0", prediction);
    end
    fetch(32'h120, BEQ_BACK);
    tests_run++;
    if (prediction !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstpri_history: got pred=%b expected 1", prediction);
    end
  endtask

  task automatic test_jump();
    fetch(32'h10, J_ABC);
    tests_run++;
    if ({prediction, JumpToAddress, S0, S1, IF_flush} !== {1'b0, 32'hABC, 3'b100}) begin
      tests_failed++;
      $display("FAIL jump: got pred=%b jta=%h s0=%b s1=%b fl=%b expected 0 00000abc 1 0 0",
               prediction, JumpToAddress, S0, S1, IF_flush);
    end
    JRSignal = 1'b1;
    #1;
    tests_run++;
    if ({S0, S1, IF_flush} !== 3'b011) begin
      tests_failed++;
      $display("FAIL jump_jr: got s0=%b s1=%b fl=%b expected 0 1 1", S0, S1, IF_flush);
    end
    JRSignal = 1'b0;
    fetch(32'h10, 32'h0);
    tests_run++;
    if (JumpToAddress !== 32'h0 || S0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL non_ctrl: got jta=%h s0=%b expected 00000000 0", JumpToAddress, S0);
    end
  endtask

  task automatic test_flush_stats();
    do_reset();
    fetch(32'h0, 32'h0);
    BranchSignal = 1'b1;
    upd_pc = 32'h50;
    upd_taken = 1'b1;
    Hit = 1'b0;
    #1;
    tests_run++;
    if ({S0, S1, IF_flush} !== 3'b111) begin
      tests_failed++;
      $display("FAIL mispredict_sel: got s0=%b s1=%b fl=%b expected 1 1 1", S0, S1, IF_flush);
    end
    @(posedge clk); #1;
    Hit = 1'b1;
    #1;
    tests_run++;
    if ({S0, S1, IF_flush} !== 3'b000) begin
      tests_failed++;
      $display("FAIL hit_sel: got s0=%b s1=%b fl=%b expected 0 0 0", S0, S1, IF_flush);
    end
    @(posedge clk); #1;
    BranchSignal = 1'b0;
    tests_run++;
    if (branch_count !== 16'd2 || mispredict_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL stats_count: got %0d/%0d expected 2/1", branch_count, mispredict_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) train(32'h60, 1'b0, 1'b0);
    tests_run++;
    if (branch_count4 !== 4'd15 || mispredict_count4 !== 4'd15) begin
      tests_failed++;
      $display("FAIL stat_sat: got %0d/%0d expected 15/15", branch_count4, mispredict_count4);
    end
    tests_run++;
    if (branch_count !== 16'd20 || mispredict_count !== 16'd20) begin
      tests_failed++;
      $display("FAIL stat_wide: got %0d/%0d expected 20/20", branch_count, mispredict_count);
    end
  endtask

  task automatic test_same_cycle();
    train(32'h35, 1'b1, 1'b0);
    fetch(32'h35, BEQ_FWD);
    BranchSignal = 1'b1;
    upd_pc = 32'h35;
    upd_taken = 1'b0;
    #1;
    tests_run++;
    if (prediction !== 1'b1 || JumpToAddress !== 32'h3A) begin
      tests_failed++;
      $display("FAIL same_cycle_old: got pred=%b jta=%h expected 1 0000003a", prediction, JumpToAddress);
    end
    @(posedge clk); #1;
    BranchSignal = 1'b0;
    tests_run++;
    if (prediction !== 1'b0 || JumpToAddress !== 32'h36) begin
      tests_failed++;
      $display("FAIL same_cycle_new: got pred=%b jta=%h expected 0 00000036", prediction, JumpToAddress);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    instruction = '0;
    PC = '0;
    PC1 = 32'd1;
    JRSignal = 1'b0;
    BranchSignal = 1'b0;
    Hit = 1'b1;
    upd_pc = '0;
    upd_taken = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    do_reset();

    test_reset();
    test_static_fallback();
    test_training();
    test_aliasing();
    test_reset_priority();
    test_jump();
    test_flush_stats();
    test_saturation();
    test_same_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dyn_branch_predictor.md
Name: dyn_branch_predictor

Overview:
- Parametrised successor to the static jump/branch unit in the fetch stage.
- Keeps the same outputs for jump decode, target computation and redirect/flush selection.
- Replaces the fixed "backward-taken" rule with a direct-mapped, tagged table of saturating counters, trained from execute.
- The static rule is kept as the fallback on a table miss. Adds saturating branch/mispredict statistics counters.

Parameters:
- ADDR_W, 32, PC/instruction width (word-addressed PCs).
- IDX_BITS, 4, table index bits; ENTRIES = 2**IDX_BITS.
- TAG_BITS, 8, tag bits taken from PC[IDX_BITS+TAG_BITS-1:IDX_BITS].
- CTR_BITS, 2, saturating counter width (>=1).
- STATIC_FALLBACK, 1, 1 = on miss predict backward-taken; 0 = on miss predict not-taken.
- STAT_W, 16, statistics counter width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- instruction, input, ADDR_W, fetched instruction.
- PC, input, ADDR_W, fetch PC (lookup key).
- PC1, input, ADDR_W, PC+1.
- JRSignal, input, 1, execute: jump-register resolved.
- BranchSignal, input, 1, execute: conditional branch resolved this cycle.
- Hit, input, 1, execute: resolved outcome matched prediction.
- upd_pc, input, ADDR_W, execute: PC of the resolving branch.
- upd_taken, input, 1, execute: actual branch outcome.
- prediction, output, 1, predicted taken for the current fetch branch.
- JumpToAddress, output, ADDR_W, predicted next-fetch address.
- S0, output, 1, PC mux select bit 0.
- S1, output, 1, PC mux select bit 1.
- IF_flush, output, 1, flush IF/ID.
- branch_count, output, STAT_W, resolved branches.
- mispredict_count, output, STAT_W, resolved branches with Hit=0.

Behaviour:
- Decode (combinational):
  - opcode = instruction[ADDR_W-1:ADDR_W-6]. J=6'h2, JAL=6'h3, BEQ=6'h4, BNE=6'h5.
  - Jump target = zero-extended instruction[25:0].
  - Branch target = PC1 + sign-extended instruction[15:0], modulo 2^ADDR_W.
  - backward = branch target < PC1 (unsigned).
- Lookup (combinational):
  - idx = PC[IDX_BITS-1:0]; tag = PC[IDX_BITS+TAG_BITS-1:IDX_BITS].
  - Table hit = valid[idx] && tag_mem[idx]==tag.
- Prediction:
  - Branch, table hit: prediction = counter MSB.
  - Branch, table miss: prediction = backward if STATIC_FALLBACK=1, else 0.
  - Any non-branch opcode (including J/JAL): prediction = 0.
- JumpToAddress:
  - J/JAL: jump target.
  - Branch with prediction=1: branch target.
  - Branch with prediction=0: PC1.
  - Otherwise: 0.
- Selects/flush (combinational, same equations as the existing unit):
  - S1 = JRSignal | (~Hit & BranchSignal).
  - S0 = (~JRSignal & (jump|branch)) | (~Hit & BranchSignal).
  - IF_flush = JRSignal | (~Hit & BranchSignal).
- Update (posedge clk, BranchSignal=1, rst=0), using uidx/utag from upd_pc:
  - Entry hit: counter increments on upd_taken=1, decrements on 0. Saturates at 2**CTR_BITS-1 and at 0.
  - Entry miss: allocate by overwriting valid/tag. Counter = weakly taken (1 followed by zeros, e.g. 2'b10) if upd_taken, else weakly not-taken (0 followed by ones, e.g. 2'b01).
  - branch_count += 1. mispredict_count += 1 if Hit=0. Both saturate at all-ones and do not wrap.
- Simultaneous lookup and update of the same index: the lookup sees the pre-update value. The new value is visible the next cycle; there is no bypass.
- JRSignal with BranchSignal: table and statistics update only on BranchSignal; flush outputs follow the equations above.
- Reset:
  - All valid bits cleared, all counters = weakly not-taken, tags = 0, both statistics counters = 0.
  - Reset takes priority over a same-cycle update; that update is dropped.
  - Combinational outputs simply reflect the reset table state (every lookup misses, so static fallback applies).
  - Reset mid-training discards all history.
- Latency: prediction is 0-cycle combinational; training takes effect after 1 cycle.

Test Plan:
- After rst: BEQ at PC=0x20 with offset -4 -> prediction=1, JumpToAddress=0x1D. Same with offset +4 -> prediction=0, JumpToAddress=0x21.
- Train PC=0x20 forward branch: upd_taken=1 twice with BranchSignal=1, Hit=0 then Hit=1 -> counter 2'b10 then 2'b11. Next fetch predicts 1 with JumpToAddress=0x25. Four not-taken updates -> counter 2'b00, not below; prediction=0.
- Aliasing: train PC=0x20, then update PC=0x120 (same idx, different tag) taken=0 -> entry retagged with counter 2'b01. Fetch at 0x20 misses and falls back to static rule.
- J at PC=0x10 with label 0x000ABC -> JumpToAddress=0xABC, prediction=0, S0=1, S1=0. With JRSignal=1 -> S1=1, S0=0, IF_flush=1.
- BranchSignal=1, Hit=0 -> S0=S1=IF_flush=1 and mispredict_count increments. With STAT_W=4, 20 such cycles -> both counters hold 15.
- Update and rst asserted in the same cycle -> table and counters reset and the update is ignored. Lookup and update at the same idx in one cycle -> lookup returns the old counter.
